// File: rtl/branch_resolve_pkg.sv
// rtl/branch_resolve_pkg.sv - branch condition encodings, FSM states and resolve helper
package branch_resolve_pkg;

   // branch condition encodings carried on br_cond
   localparam logic [2:0] BR_EQ     = 3'd0;
   localparam logic [2:0] BR_NE     = 3'd1;
   localparam logic [2:0] BR_LT     = 3'd2;
   localparam logic [2:0] BR_GT     = 3'd3;
   localparam logic [2:0] BR_LE     = 3'd4;
   localparam logic [2:0] BR_GE     = 3'd5;
   localparam logic [2:0] BR_ALWAYS = 3'd6;
   localparam logic [2:0] BR_NEVER  = 3'd7;

   // sequential fall-through distance (one 32-bit instruction)
   localparam int FALLTHROUGH_INC = 4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_FLUSH    = 2'd2
   } br_state_e;

   typedef struct packed {
      logic eq;
      logic ne;
      logic lt;
      logic gt;
      logic le;
      logic ge;
   } br_flags_t;

   // pick the flag named by the condition; ALWAYS/NEVER ignore the flags
   function automatic logic cond_taken(input logic [2:0] cond, input br_flags_t f);
      logic t;
      case (cond)
         BR_EQ:     t = f.eq;
         BR_NE:     t = f.ne;
         BR_LT:     t = f.lt;
         BR_GT:     t = f.gt;
         BR_LE:     t = f.le;
         BR_GE:     t = f.ge;
         BR_ALWAYS: t = 1'b1;
         default:   t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/branch_resolve_bht_2bit.sv
// rtl/branch_resolve_bht_2bit.sv - table of 2-bit saturating branch direction counters
module bht_2bit #(
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_pred,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_taken
);

   localparam int ENTRIES = 1 << IDX_W;

   logic [1:0] ctr [ENTRIES];

   // counters start weakly not-taken and saturate at 00 / 11
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ctr[i] <= 2'b01;
         end
      end else if (wr_en) begin
         if (wr_taken && ctr[wr_idx] != 2'b11) begin
            ctr[wr_idx] <= ctr[wr_idx] + 2'b01;
         end else if (!wr_taken && ctr[wr_idx] != 2'b00) begin
            ctr[wr_idx] <= ctr[wr_idx] - 2'b01;
         end
      end
   end

   // read is asynchronous, so a same-cycle write is not yet visible
   assign rd_pred = ctr[rd_idx][1];

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - execute-stage branch resolve, redirect/flush FSM, optional BHT (BRANCH_PRED_EN)
module branch_resolve
   import branch_resolve_pkg::*;
#(
   parameter int PC_W         = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int BHT_IDX_W    = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            br_valid,
   input  logic [2:0]      br_cond,
   input  logic            EQ,
   input  logic            NE,
   input  logic            LT,
   input  logic            GT,
   input  logic            LE,
   input  logic            GE,
   input  logic [PC_W-1:0] br_pc,
   input  logic [PC_W-1:0] br_target,
   input  logic            pred_taken,
   input  logic [PC_W-1:0] fetch_pc,
   output logic            fetch_pred,
   input  logic            redir_ready,
   output logic            redir_valid,
   output logic [PC_W-1:0] redir_pc,
   output logic            flush,
   output logic            stall,
   output logic            resolved_taken,
   output logic            mispredict
);

   localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   br_state_e       state;
   logic [CNT_W-1:0] cnt;
   br_flags_t       flags;
   logic            taken;
   logic [PC_W-1:0] fallthrough;
   logic            accept;

   // resolve direction and sequential PC for the branch in execute
   always_comb begin
      flags       = '{eq: EQ, ne: NE, lt: LT, gt: GT, le: LE, ge: GE};
      taken       = cond_taken(br_cond, flags);
      fallthrough = br_pc + PC_W'(FALLTHROUGH_INC);
      accept      = br_valid && (state == ST_IDLE);
   end

   // redirect/flush sequencer; every output is registered alongside the state
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         redir_valid    <= 1'b0;
         redir_pc       <= '0;
         flush          <= 1'b0;
         stall          <= 1'b0;
         resolved_taken <= 1'b0;
         mispredict     <= 1'b0;
      end else begin
         resolved_taken <= 1'b0;
         mispredict     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  resolved_taken <= taken;
                  mispredict     <= (taken != pred_taken);
                  if (taken != pred_taken) begin
                     redir_pc    <= taken ? br_target : fallthrough;
                     redir_valid <= 1'b1;
                     flush       <= 1'b1;
                     stall       <= 1'b1;
                     state       <= ST_REDIRECT;
                  end
               end
            end
            ST_REDIRECT: begin
               // redir_valid is always high here, so ready alone completes the handshake
               if (redir_ready) begin
                  redir_valid <= 1'b0;
                  cnt         <= CNT_W'(FLUSH_CYCLES - 1);
                  state       <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (cnt == '0) begin
                  flush <= 1'b0;
                  stall <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef BRANCH_PRED_EN
   logic unused_fetch_pc_bits;
   assign unused_fetch_pc_bits = ^{fetch_pc[PC_W-1:BHT_IDX_W+2], fetch_pc[1:0]};

   bht_2bit #(
      .IDX_W (BHT_IDX_W)
   ) u_bht (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (fetch_pc[BHT_IDX_W+1:2]),
      .rd_pred  (fetch_pred),
      .wr_en    (accept),
      .wr_idx   (br_pc[BHT_IDX_W+1:2]),
      .wr_taken (taken)
   );
`else
   logic unused_fetch_pc;
   assign unused_fetch_pc = ^fetch_pc;
   // static not-taken prediction
   assign fetch_pred = 1'b0;
`endif

endmodule
